// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: assembles 16- or 32-bit instructions from a
// half-word instruction memory and hands them to the decoder one at a time.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic        dec_is_32,
    output logic [15:0] dec_pc
);

    localparam logic [1:0] FETCH_LO = 2'd0;
    localparam logic [1:0] FETCH_HI = 2'd1;
    localparam logic [1:0] ISSUE    = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] lo_word;
    logic [15:0] hi_word;
    logic        is_32;
    // Set on the first edge that sees reset released; keeps mem_req low until then.
    logic        running;

    always_comb begin
        mem_req   = running && (state == FETCH_LO || state == FETCH_HI);
        mem_addr  = (state == FETCH_HI) ? pc + 16'd1 : pc;
        dec_valid = (state == ISSUE);
        dec_instr = {hi_word, lo_word};
        dec_is_32 = is_32;
        dec_pc    = pc;
    end

    // A branch overrides everything, including an ack or a decoder handshake
    // arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= FETCH_LO;
            pc      <= RESET_PC;
            lo_word <= 16'h0000;
            hi_word <= 16'h0000;
            is_32   <= 1'b0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (branch_valid) begin
                pc    <= branch_target;
                state <= FETCH_LO;
            end else begin
                case (state)
                    FETCH_LO: begin
                        if (mem_req && mem_ack) begin
                            lo_word <= mem_data;
                            if (mem_data[15]) begin
                                state <= FETCH_HI;
                            end else begin
                                hi_word <= 16'h0000;
                                is_32   <= 1'b0;
                                state   <= ISSUE;
                            end
                        end
                    end
                    FETCH_HI: begin
                        if (mem_req && mem_ack) begin
                            hi_word <= mem_data;
                            is_32   <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (dec_ready) begin
                            pc    <= pc + (is_32 ? 16'd2 : 16'd1);
                            state <= FETCH_LO;
                        end
                    end
                    default: state <= FETCH_LO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked against an instruction-stream model over a memory image.
module tb_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic        dec_is_32;
    logic [15:0] dec_pc;

    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    // Model: the instruction at m_pc, how many of its half-words have been
    // delivered so far, and whether it is complete and waiting for the decoder.
    logic        m_in_reset = 1'b1;
    logic [15:0] m_pc       = RESET_PC;
    logic [15:0] m_halves   = 16'd0;
    logic        m_issue    = 1'b0;

    fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_is_32     (dec_is_32),
        .dec_pc        (dec_pc)
    );

    always #5 clock = ~clock;

    assign mem_data = mem[mem_addr];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] words_needed(input logic [15:0] pc);
        return mem[pc][15] ? 16'd2 : 16'd1;
    endfunction

    function automatic logic [31:0] model_instr(input logic [15:0] pc);
        logic [15:0] nxt;
        nxt = pc + 16'd1;
        if (mem[pc][15])
            return {mem[nxt], mem[pc]};
        return {16'h0000, mem[pc]};
    endfunction

    // One cycle: at the falling edge compare outputs with the model, then drive
    // inputs for the next rising edge and advance the model across that edge.
    task automatic step(input logic rst, input logic ack, input logic rdy,
                        input logic br, input logic [15:0] tgt);
        logic exp_req;
        @(negedge clock);
        exp_req = !m_in_reset && !m_issue;
        if (m_in_reset) begin
            check_value("rst_mem_req",   {31'd0, mem_req},   32'd0);
            check_value("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
            check_value("rst_dec_instr", dec_instr,          32'd0);
            check_value("rst_dec_is_32", {31'd0, dec_is_32}, 32'd0);
            check_value("rst_dec_pc",    {16'd0, dec_pc},    {16'd0, RESET_PC});
        end else begin
            check_value("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (exp_req)
                check_value("mem_addr", {16'd0, mem_addr}, {16'd0, m_pc + m_halves});
            check_value("dec_valid", {31'd0, dec_valid}, {31'd0, m_issue});
            if (m_issue) begin
                check_value("dec_instr", dec_instr, model_instr(m_pc));
                check_value("dec_is_32", {31'd0, dec_is_32}, {31'd0, mem[m_pc][15]});
                check_value("dec_pc", {16'd0, dec_pc}, {16'd0, m_pc});
            end
        end
        reset_n       = rst;
        mem_ack       = ack;
        dec_ready     = rdy;
        branch_valid  = br;
        branch_target = tgt;
        if (!rst) begin
            m_in_reset = 1'b1;
            m_pc       = RESET_PC;
            m_halves   = 16'd0;
            m_issue    = 1'b0;
        end else begin
            m_in_reset = 1'b0;
            if (br) begin
                m_pc     = tgt;
                m_halves = 16'd0;
                m_issue  = 1'b0;
            end else if (m_issue && rdy) begin
                m_pc     = m_pc + words_needed(m_pc);
                m_halves = 16'd0;
                m_issue  = 1'b0;
            end else if (exp_req && ack) begin
                m_halves = m_halves + 16'd1;
                if (m_halves == words_needed(m_pc))
                    m_issue = 1'b1;
            end
        end
    endtask

    initial begin
        logic        r_rst, r_ack, r_rdy, r_br;
        logic [15:0] r_tgt;
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h5555;
        mem[16'h0001] = 16'h1111;
        mem[16'h0004] = 16'h8A01;
        mem[16'h0005] = 16'h1234;
        mem[16'h0006] = 16'h9ABC;
        mem[16'h0007] = 16'h4321;
        mem[16'hFFFF] = 16'h8000;

        // Reset, then the first request appears one cycle after release.
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_value("reset_req", {31'd0, mem_req}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("release_req", {31'd0, mem_req}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_value("first_req", {31'd0, mem_req}, 32'd1);

        // 16-bit instruction at address 0.
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_value("i16_instr", dec_instr, 32'h0000_5555);
        check_value("i16_is_32", {31'd0, dec_is_32}, 32'd0);
        check_value("i16_pc", {16'd0, dec_pc}, 32'd0);

        // Next fetch at 1; branch to 4 with a colliding ack that must be dropped.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004);
        check_value("i16_next_addr", {16'd0, mem_addr}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("i32_lo_addr", {16'd0, mem_addr}, 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("i32_hi_addr", {16'd0, mem_addr}, 32'd5);

        // 32-bit instruction held for five stalled cycles.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            check_value("stall_instr", dec_instr, 32'h1234_8A01);
            check_value("stall_req", {31'd0, mem_req}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_value("i32_is_32", {31'd0, dec_is_32}, 32'd1);
        check_value("i32_pc", {16'd0, dec_pc}, 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_value("i32_next_req", {31'd0, mem_req}, 32'd1);
        check_value("i32_next_addr", {16'd0, mem_addr}, 32'd6);

        // Branch while the high half is being acknowledged.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040);
        check_value("brhi_addr", {16'd0, mem_addr}, 32'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        check_value("brhi_valid", {31'd0, dec_valid}, 32'd0);
        check_value("brhi_target", {16'd0, mem_addr}, 32'h0040);

        // 32-bit instruction straddling the top of the address space.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("wrap_lo_addr", {16'd0, mem_addr}, 32'hFFFF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("wrap_hi_addr", {16'd0, mem_addr}, 32'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_value("wrap_pc", {16'd0, dec_pc}, 32'hFFFF);
        check_value("wrap_instr", dec_instr, 32'h5555_8000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_value("wrap_next_addr", {16'd0, mem_addr}, 32'h0001);

        // Reset while an instruction is being offered.
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_value("rstiss_valid_before", {31'd0, dec_valid}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_value("rstiss_valid_after", {31'd0, dec_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_value("rstiss_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});
        check_value("rstiss_req", {31'd0, mem_req}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 199) != 0);
            r_ack = ($urandom_range(0, 2) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_br  = ($urandom_range(0, 15) == 0);
            r_tgt = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
            step(r_rst, r_ack, r_rdy, r_br, r_tgt);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
